// File: rtl/dsp_mul_arbiter.sv
// dsp_mul_arbiter: shares one pipelined DSP multiplier among NREQ requesters, with a tag/ID
// shadow pipeline to route products back. Define DSP_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module dsp_mul_arbiter #(
    parameter int NREQ = 2,
    parameter int L    = 17,
    parameter int K    = 17,
    parameter int LAT  = 2,
    parameter int TAGW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   gnt_en,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*L-1:0]      req_a,
    input  logic [NREQ*K-1:0]      req_b,
    input  logic [NREQ*TAGW-1:0]   req_tag,
    output logic [NREQ-1:0]        resp_valid,
    output logic [47:0]            resp_p,
    output logic [TAGW-1:0]        resp_tag,
    output logic                   busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   winner;
    logic            any_req;
    logic            hs;
    int              idx;
    logic [26:0]     a_iss;
    logic [17:0]     b_iss;

    logic            v_d;
    logic [PW-1:0]   id_d;
    logic [TAGW-1:0] tag_d;

    logic [LAT-1:0]  v_q;
    logic [PW-1:0]   id_q  [LAT];
    logic [TAGW-1:0] tag_q [LAT];
    logic [47:0]     p_q   [LAT];
    logic            v_out;

    // Scan offsets high to low so the last hit (smallest offset from ptr) wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = (int'(ptr_q) + off) % NREQ;
            if (req_valid[idx]) begin
                winner  = PW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        hs                = any_req & gnt_en & rst_n;
        req_ready         = '0;
        req_ready[winner] = hs;
        a_iss             = '0;
        b_iss             = '0;
        if (hs) begin
            a_iss = 27'(req_a[int'(winner)*L +: L]);
            b_iss = 18'(req_b[int'(winner)*K +: K]);
        end
        v_d   = hs;
        id_d  = winner;
        tag_d = req_tag[int'(winner)*TAGW +: TAGW];
    end

`ifdef DSP_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    // DSP product pipeline is deliberately not reset; stale products are masked by v.
    always_ff @(posedge clk) begin
        p_q[0] <= 48'(a_iss) * 48'(b_iss);
        for (int i = 1; i < LAT; i++) p_q[i] <= p_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                id_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            v_q[0]   <= v_d;
            id_q[0]  <= id_d;
            tag_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) begin
                v_q[i]   <= v_q[i-1];
                id_q[i]  <= id_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        v_out                    = v_q[LAT-1] & rst_n;
        resp_valid               = '0;
        resp_valid[id_q[LAT-1]]  = v_out;
        resp_tag                 = v_out ? tag_q[LAT-1] : '0;
        resp_p                   = p_q[LAT-1];
        busy                     = rst_n & (|v_q);
    end
endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Bench for dsp_mul_arbiter: four instances (LAT=1..4) share stimulus and are checked every cycle
// against an issue-history model, plus directed literal expectations.
module tb_dsp_mul_arbiter;
    localparam int NREQ = 2, L = 17, K = 17, TAGW = 4, NI = 4, HMAX = 1024;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 gnt_en;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*L-1:0]    req_a;
    logic [NREQ*K-1:0]    req_b;
    logic [NREQ*TAGW-1:0] req_tag;

    logic [NREQ-1:0] rdy_w  [NI];
    logic [NREQ-1:0] rv_w   [NI];
    logic [47:0]     rp_w   [NI];
    logic [TAGW-1:0] tag_w  [NI];
    logic            busy_w [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dsp_mul_arbiter #(.NREQ(NREQ), .L(L), .K(K), .LAT(g + 1), .TAGW(TAGW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .gnt_en    (gnt_en),
            .req_valid (req_valid),
            .req_ready (rdy_w[g]),
            .req_a     (req_a),
            .req_b     (req_b),
            .req_tag   (req_tag),
            .resp_valid(rv_w[g]),
            .resp_p    (rp_w[g]),
            .resp_tag  (tag_w[g]),
            .busy      (busy_w[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Issue history: what was accepted in each cycle and whether reset was asserted then.
    bit              h_rst [HMAX];
    bit              h_v   [HMAX];
    int              h_id  [HMAX];
    logic [TAGW-1:0] h_tag [HMAX];
    longint          h_p   [HMAX];

    function automatic bit no_rst(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) if (h_rst[j]) return 1'b0;
        return 1'b1;
    endfunction

    int mptr = 0;
    int m_idx, m_ew, m_c, m_j, m_lat;
    bit m_ehs, m_ok, m_busy;

    always @(negedge clk) begin
        m_c = cyc;
        if (m_c < HMAX) begin
            h_rst[m_c] = !rst_n;
            m_ehs = 1'b0;
            m_ew  = 0;
            if (rst_n && gnt_en) begin
                for (int off = 0; off < NREQ; off++) begin
`ifdef DSP_ARB_FIXED_PRIO_EN
                    m_idx = off;
`else
                    m_idx = (mptr + off) % NREQ;
`endif
                    if (!m_ehs && req_valid[m_idx]) begin
                        m_ehs = 1'b1;
                        m_ew  = m_idx;
                    end
                end
            end
            h_v[m_c]   = m_ehs;
            h_id[m_c]  = m_ew;
            h_tag[m_c] = req_tag[m_ew*TAGW +: TAGW];
            h_p[m_c]   = longint'(req_a[m_ew*L +: L]) * longint'(req_b[m_ew*K +: K]);

            for (int k = 0; k < NI; k++) begin
                m_lat = k + 1;
                chk($sformatf("ready_lat%0d", m_lat), 64'(rdy_w[k]),
                    m_ehs ? 64'(1) << m_ew : 64'(0));
                m_j  = m_c - m_lat;
                m_ok = (m_j >= 0) && h_v[m_j] && no_rst(m_j + 1, m_c);
                chk($sformatf("resp_valid_lat%0d", m_lat), 64'(rv_w[k]),
                    m_ok ? 64'(1) << h_id[m_j] : 64'(0));
                chk($sformatf("resp_tag_lat%0d", m_lat), 64'(tag_w[k]),
                    m_ok ? 64'(h_tag[m_j]) : 64'(0));
                if (m_ok) chk($sformatf("resp_p_lat%0d", m_lat), 64'(rp_w[k]), 64'(h_p[m_j]));
                m_busy = 1'b0;
                for (int j = m_c - m_lat; j < m_c; j++)
                    if (j >= 0 && h_v[j] && no_rst(j + 1, m_c)) m_busy = 1'b1;
                chk($sformatf("busy_lat%0d", m_lat), 64'(busy_w[k]), 64'(m_busy));
            end

`ifndef DSP_ARB_FIXED_PRIO_EN
            if (!rst_n)     mptr = 0;
            else if (m_ehs) mptr = (m_ew + 1) % NREQ;
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; gnt_en = 1'b1; req_valid = '0;
        req_a = '0; req_b = '0; req_tag = '0;
        @(negedge clk);
        chk("reset_ready", 64'(rdy_w[1]), 64'(0));
        chk("reset_busy", 64'(busy_w[1]), 64'(0));
        repeat (3) tick();

        // Single request from req0, LAT=2 instance
        rst_n = 1'b1; req_valid = 2'b01;
        req_a[0 +: L] = 17'd3; req_b[0 +: K] = 17'd5; req_tag[0 +: TAGW] = 4'd1;
        @(negedge clk);
        chk("t1_ready", 64'(rdy_w[1]), 64'(2'b01));
        tick(); req_valid = '0;
        tick();
        @(negedge clk);
        chk("t1_resp_valid", 64'(rv_w[1]), 64'(2'b01));
        chk("t1_resp_p", 64'(rp_w[1]), 64'd15);
        chk("t1_resp_tag", 64'(tag_w[1]), 64'd1);

        // Both requesting continuously from ptr=0
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        req_a = {17'd30, 17'd10}; req_b = {17'd40, 17'd20}; req_tag = {4'd3, 4'd2};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
`ifdef DSP_ARB_FIXED_PRIO_EN
            chk("t6_ready", 64'(rdy_w[1]), 64'(2'b01));
            if (i >= 2) begin
                chk("t6_resp_valid", 64'(rv_w[1]), 64'(2'b01));
                chk("t6_resp_tag", 64'(tag_w[1]), 64'd2);
                chk("t6_resp_p", 64'(rp_w[1]), 64'd200);
            end
`else
            chk("t2_ready", 64'(rdy_w[1]), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            if (i >= 2) begin
                chk("t2_resp_valid", 64'(rv_w[1]), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
                chk("t2_resp_tag", 64'(tag_w[1]), (i % 2 == 0) ? 64'd2 : 64'd3);
                chk("t2_resp_p", 64'(rp_w[1]), (i % 2 == 0) ? 64'd200 : 64'd1200);
            end
`endif
            tick();
        end
        req_valid = 2'b10;
        @(negedge clk);
        chk("t2_req1_alone", 64'(rdy_w[1]), 64'(2'b10));
        tick(); req_valid = '0;
        repeat (4) tick();

        // Maximum operands across LAT=1..4
        req_a[0 +: L] = '1; req_b[0 +: K] = '1; req_tag[0 +: TAGW] = 4'd9;
        req_valid = 2'b01;
        @(negedge clk);
        chk("t3_ready", 64'(rdy_w[0]), 64'(2'b01));
        tick(); req_valid = '0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            chk($sformatf("t3_p_lat%0d", t), 64'(rp_w[t-1]), 64'h3_FFFC_0001);
            chk($sformatf("t3_valid_lat%0d", t), 64'(rv_w[t-1]), 64'(2'b01));
            if (t < 4) tick();
        end
        tick();
        repeat (3) tick();

        // Reset with operations in flight
        req_valid = 2'b11;
        repeat (3) tick();
        rst_n = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("t4_busy_in_reset", 64'(busy_w[3]), 64'(0));
        tick(); rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk("t4_no_resp", 64'(rv_w[k]), 64'(0));
                chk("t4_busy", 64'(busy_w[k]), 64'(0));
            end
            tick();
        end
        req_valid = 2'b11;
        @(negedge clk);
        chk("t4_first_grant", 64'(rdy_w[1]), 64'(2'b01));

        // Grants disabled while requests pend
        tick(); gnt_en = 1'b0;
        @(negedge clk);
        chk("t5_ready_off", 64'(rdy_w[1]), 64'(0));
        chk("t5_busy_inflight", 64'(busy_w[1]), 64'(1));
        tick();
        @(negedge clk);
        chk("t5_ready_off2", 64'(rdy_w[1]), 64'(0));
        chk("t5_drain_resp", 64'(rv_w[1]), 64'(2'b01));
        tick();
        @(negedge clk);
        chk("t5_busy_drained", 64'(busy_w[1]), 64'(0));
        chk("t5_no_resp", 64'(rv_w[1]), 64'(0));
        tick(); gnt_en = 1'b1;
        @(negedge clk);
`ifdef DSP_ARB_FIXED_PRIO_EN
        chk("t5_regrant", 64'(rdy_w[1]), 64'(2'b01));
`else
        chk("t5_regrant", 64'(rdy_w[1]), 64'(2'b10));
`endif
        tick(); req_valid = '0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
